// File: rtl/quire_to_posit.sv
// Rounds two's-complement quire words to posit<POSIT_WIDTH, POSIT_ES> on an rts/rtr stream.
// A one-word skid latch feeds a decode / normalise / encode / round-and-sign pipeline.
module quire_to_posit #(
    parameter int unsigned POSIT_WIDTH  = 8,
    parameter int unsigned POSIT_ES     = 0,
    parameter int unsigned LOG_NB_ACCUM = 15,
    localparam int unsigned QUIRE_SIZE  =
        (2 ** (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 1 + LOG_NB_ACCUM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rts_i,
    output logic                   rtr_o,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [QUIRE_SIZE-1:0]  data_i,
    input  logic                   NaR_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [POSIT_WIDTH-1:0] posit_o
);

    localparam int unsigned N        = POSIT_WIDTH;
    localparam int unsigned ES       = POSIT_ES;
    localparam int unsigned NQ       = QUIRE_SIZE;
    localparam int unsigned BPP      = (2 ** (ES + 1)) * (N - 2);
    localparam int unsigned MAXSCALE = (N - 2) * (2 ** ES);
    localparam int unsigned FW       = NQ - 1;
    localparam int unsigned PW       = $clog2(NQ);
    localparam int unsigned SW       = PW + 2;
    localparam int unsigned EF       = ES + FW;
    localparam int unsigned RW       = EF + 2 + N;

    localparam logic signed [SW-1:0] SCALE_MAX = SW'(MAXSCALE);
    localparam logic signed [SW-1:0] SCALE_MIN = SW'(-int'(MAXSCALE));

    // ------------------------------------------------------------------
    // Handshake and skid latch
    // ------------------------------------------------------------------
    logic          process_en;
    logic          receive_en;
    logic          latched_q;
    logic [NQ-1:0] skid_data_q;
    logic          skid_nar_q;
    logic          skid_sow_q;
    logic          skid_eow_q;
    logic [3:0]    valid_q;

    assign rts_o      = valid_q[3];
    assign process_en = rtr_i | ~rts_o;
    assign receive_en = rts_i & rtr_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_o       <= 1'b0;
            latched_q   <= 1'b0;
            skid_data_q <= '0;
            skid_nar_q  <= 1'b0;
            skid_sow_q  <= 1'b0;
            skid_eow_q  <= 1'b0;
        end else begin
            rtr_o <= process_en;
            // rtr_o lags process_en by a cycle, so one word can arrive during a stall
            if (receive_en && !process_en) begin
                latched_q   <= 1'b1;
                skid_data_q <= data_i;
                skid_nar_q  <= NaR_i;
                skid_sow_q  <= sow_i;
                skid_eow_q  <= eow_i;
            end else if (process_en) begin
                latched_q <= 1'b0;
            end
        end
    end

    logic          src_valid;
    logic          src_nar;
    logic          src_sow;
    logic          src_eow;
    logic [NQ-1:0] src_data;

    always_comb begin
        src_valid = receive_en | latched_q;
        if (latched_q) begin
            src_data = skid_data_q;
            src_nar  = skid_nar_q;
            src_sow  = skid_sow_q;
            src_eow  = skid_eow_q;
        end else begin
            src_data = data_i;
            src_nar  = NaR_i;
            src_sow  = sow_i;
            src_eow  = eow_i;
        end
    end

    // ------------------------------------------------------------------
    // S1: special decode and magnitude
    // ------------------------------------------------------------------
    logic [NQ-1:0] s1_mag_d;

    // The most negative quire wraps to 2^(NQ-1), which is exactly its magnitude unsigned
    assign s1_mag_d = src_data[NQ-1] ? (~src_data + NQ'(1)) : src_data;

    logic          s1_nar_q;
    logic          s1_zero_q;
    logic          s1_sign_q;
    logic [NQ-1:0] s1_mag_q;
    logic          s1_sow_q;
    logic          s1_eow_q;

    // ------------------------------------------------------------------
    // S2: leading-one detection and normalisation
    // ------------------------------------------------------------------
    logic [PW-1:0] lead;
    logic [PW-1:0] shamt;
    logic [NQ-1:0] norm;
    logic [SW-1:0] s2_scale_d;

    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < NQ; i++) begin
            if (s1_mag_q[i]) lead = PW'(i);
        end
        shamt      = PW'(NQ - 1) - lead;
        norm       = s1_mag_q << shamt;
        s2_scale_d = SW'(lead) - SW'(BPP);
    end

    logic                 s2_nar_q;
    logic                 s2_zero_q;
    logic                 s2_sign_q;
    logic signed [SW-1:0] s2_scale_q;
    logic [FW-1:0]        s2_frac_q;
    logic                 s2_sow_q;
    logic                 s2_eow_q;

    // ------------------------------------------------------------------
    // S3: regime/exponent/fraction assembly and rounding decision
    // ------------------------------------------------------------------
    logic signed [SW-1:0] k;
    logic [SW-1:0]        amt;
    logic [SW+FW-1:0]     rem_ext;
    logic [EF-1:0]        rem;
    logic [RW-1:0]        reg_pos;
    logic [RW-1:0]        reg_neg;
    logic signed [RW-1:0] pos_shift;
    logic [RW-1:0]        full;
    logic [N-2:0]         body_raw;
    logic                 guard;
    logic                 sticky;
    logic [N-2:0]         s3_body_d;
    logic                 s3_round_d;

    always_comb begin
        k       = s2_scale_q >>> ES;
        // For negative k the regime needs -k zeros; ~k == -k-1 shifts past the leading 0
        amt     = k[SW-1] ? ~k : k;
        rem_ext = {s2_scale_q, s2_frac_q};
        rem     = rem_ext[EF-1:0];
        reg_pos = {2'b10, rem, {N{1'b0}}};
        reg_neg = {2'b01, rem, {N{1'b0}}};
        pos_shift = $signed(reg_pos) >>> amt;
        if (k[SW-1]) begin
            full = reg_neg >> amt;
        end else begin
            full = pos_shift;
        end
        body_raw = full[RW-1 -: N-1];
        guard    = full[RW-N];
        sticky   = |full[RW-N-1:0];

        if (s2_scale_q > SCALE_MAX) begin
            s3_body_d  = '1;
            s3_round_d = 1'b0;
        end else if (s2_scale_q < SCALE_MIN) begin
            s3_body_d  = {{(N-2){1'b0}}, 1'b1};
            s3_round_d = 1'b0;
        end else begin
            s3_body_d  = body_raw;
            // An all-ones body must not wrap into the NaR pattern
            s3_round_d = guard & (sticky | body_raw[0]) & ~(&body_raw);
        end
    end

    logic         s3_nar_q;
    logic         s3_zero_q;
    logic         s3_sign_q;
    logic [N-2:0] s3_body_q;
    logic         s3_round_q;
    logic         s3_sow_q;
    logic         s3_eow_q;

    // ------------------------------------------------------------------
    // Output: round increment, specials and sign application
    // ------------------------------------------------------------------
    logic [N-2:0] body_rnd;
    logic [N-1:0] pos_abs;
    logic [N-1:0] posit_d;

    always_comb begin
        body_rnd = s3_body_q + {{(N-2){1'b0}}, s3_round_q};
        pos_abs  = {1'b0, body_rnd};
        if (s3_nar_q) begin
            posit_d = {1'b1, {(N-1){1'b0}}};
        end else if (s3_zero_q) begin
            posit_d = '0;
        end else if (s3_sign_q) begin
            posit_d = ~pos_abs + N'(1);
        end else begin
            posit_d = pos_abs;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: every rank advances together on process_en
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            s1_nar_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_sow_q   <= 1'b0;
            s1_eow_q   <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_scale_q <= '0;
            s2_frac_q  <= '0;
            s2_sow_q   <= 1'b0;
            s2_eow_q   <= 1'b0;
            s3_nar_q   <= 1'b0;
            s3_zero_q  <= 1'b0;
            s3_sign_q  <= 1'b0;
            s3_body_q  <= '0;
            s3_round_q <= 1'b0;
            s3_sow_q   <= 1'b0;
            s3_eow_q   <= 1'b0;
            sow_o      <= 1'b0;
            eow_o      <= 1'b0;
            posit_o    <= '0;
        end else if (process_en) begin
            valid_q <= {valid_q[2:0], src_valid};
            if (src_valid) begin
                s1_nar_q  <= src_nar;
                s1_zero_q <= ~|src_data;
                s1_sign_q <= src_data[NQ-1];
                s1_mag_q  <= s1_mag_d;
                s1_sow_q  <= src_sow;
                s1_eow_q  <= src_eow;
            end
            if (valid_q[0]) begin
                s2_nar_q   <= s1_nar_q;
                s2_zero_q  <= s1_zero_q;
                s2_sign_q  <= s1_sign_q;
                s2_scale_q <= s2_scale_d;
                s2_frac_q  <= norm[NQ-2:0];
                s2_sow_q   <= s1_sow_q;
                s2_eow_q   <= s1_eow_q;
            end
            if (valid_q[1]) begin
                s3_nar_q   <= s2_nar_q;
                s3_zero_q  <= s2_zero_q;
                s3_sign_q  <= s2_sign_q;
                s3_body_q  <= s3_body_d;
                s3_round_q <= s3_round_d;
                s3_sow_q   <= s2_sow_q;
                s3_eow_q   <= s2_eow_q;
            end
            if (valid_q[2]) begin
                sow_o   <= s3_sow_q;
                eow_o   <= s3_eow_q;
                posit_o <= posit_d;
            end
        end
    end

    // sign_i and zero_i are redundant with data_i; the leading one itself is not a fraction bit
    logic unused_bits;
    assign unused_bits = ^{sign_i, zero_i, norm[NQ-1], rem_ext[SW+FW-1:EF]};

endmodule

// File: tb/tb_quire_to_posit.sv
// Directed bench for quire_to_posit at n=8, es=0 (nq=40, quire bit 12 = 1.0).
module tb_quire_to_posit;

    localparam int unsigned NQ = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rts_i;
    logic          rtr_o;
    logic          sow_i;
    logic          eow_i;
    logic [NQ-1:0] data_i;
    logic          NaR_i;
    logic          sign_i;
    logic          zero_i;
    logic          rtr_i;
    logic          rts_o;
    logic          sow_o;
    logic          eow_o;
    logic [7:0]    posit_o;

    quire_to_posit #(
        .POSIT_WIDTH  (8),
        .POSIT_ES     (0),
        .LOG_NB_ACCUM (15)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rts_i   (rts_i),
        .rtr_o   (rtr_o),
        .sow_i   (sow_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .NaR_i   (NaR_i),
        .sign_i  (sign_i),
        .zero_i  (zero_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .sow_o   (sow_o),
        .eow_o   (eow_o),
        .posit_o (posit_o)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [NQ-1:0] d, input logic nar, input logic sow,
                         input logic eow);
        rts_i  = 1'b1;
        data_i = d;
        NaR_i  = nar;
        sign_i = d[NQ-1];
        zero_i = (d == '0);
        sow_i  = sow;
        eow_i  = eow;
    endtask

    // Single word through an idle pipe: checks the 3-cycle latency and the posit value
    task automatic convert(input string tag, input logic [NQ-1:0] d, input logic nar,
                           input logic [7:0] exp);
        int lat;
        int wait_cyc;
        @(negedge clk);
        wait_cyc = 0;
        while (!rtr_o && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({tag, " rtr"}, rtr_o, 1);
        drive(d, nar, 1'b1, 1'b1);
        @(negedge clk);
        rts_i = 1'b0;
        lat = 0;
        while (!rts_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check(tag, posit_o, exp);
    endtask

    logic [NQ-1:0] bp_data  [8];
    logic [7:0]    bp_posit [8];
    int            drv_i;
    int            drv_budget;
    int            mon_j;
    int            mon_cyc;
    logic          held;
    logic [9:0]    prev_out;
    int            spurious;

    initial begin
        rst_n  = 1'b0;
        rts_i  = 1'b0;
        sow_i  = 1'b0;
        eow_i  = 1'b0;
        data_i = '0;
        NaR_i  = 1'b0;
        sign_i = 1'b0;
        zero_i = 1'b0;
        rtr_i  = 1'b1;

        repeat (2) @(negedge clk);
        check("reset state", {rtr_o, rts_o, sow_o, eow_o, posit_o}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rtr after reset", rtr_o, 1);

        convert("one",          40'h00_0000_1000, 1'b0, 8'h40);
        convert("minus one",    40'hFF_FFFF_F000, 1'b0, 8'hC0);
        convert("one and half", 40'h00_0000_1800, 1'b0, 8'h50);
        convert("nar",          40'h00_0000_1000, 1'b1, 8'h80);
        convert("zero",         40'h00_0000_0000, 1'b0, 8'h00);
        convert("nar zero",     40'h00_0000_0000, 1'b1, 8'h80);
        convert("maxpos",       40'h01_0000_0000, 1'b0, 8'h7F);
        convert("minpos",       40'h00_0000_0001, 1'b0, 8'h01);
        convert("most neg",     40'h80_0000_0000, 1'b0, 8'h81);
        convert("tie even",     40'h00_0000_1040, 1'b0, 8'h40);
        convert("tie odd",      40'h00_0000_10C0, 1'b0, 8'h42);
        convert("above tie",    40'h00_0000_1041, 1'b0, 8'h41);

        // Back-to-back stream with a 4-cycle downstream stall
        bp_data[0] = 40'h00_0000_1000;  bp_posit[0] = 8'h40;
        bp_data[1] = 40'hFF_FFFF_F000;  bp_posit[1] = 8'hC0;
        bp_data[2] = 40'h00_0000_1800;  bp_posit[2] = 8'h50;
        bp_data[3] = 40'h00_0000_1040;  bp_posit[3] = 8'h40;
        bp_data[4] = 40'h00_0000_10C0;  bp_posit[4] = 8'h42;
        bp_data[5] = 40'h00_0000_1041;  bp_posit[5] = 8'h41;
        bp_data[6] = 40'h01_0000_0000;  bp_posit[6] = 8'h7F;
        bp_data[7] = 40'h80_0000_0000;  bp_posit[7] = 8'h81;
        drv_i      = 0;
        drv_budget = 0;
        mon_j      = 0;
        mon_cyc    = 0;
        held       = 1'b0;
        prev_out   = '0;
        fork
            begin
                while (drv_i < 8 && drv_budget < 200) begin
                    @(negedge clk);
                    drive(bp_data[drv_i], 1'b0, drv_i == 0, drv_i == 7);
                    if (rtr_o) drv_i++;
                    drv_budget++;
                end
                @(negedge clk);
                rts_i = 1'b0;
                sow_i = 1'b0;
                eow_i = 1'b0;
            end
            begin
                while (mon_j < 8 && mon_cyc < 200) begin
                    @(negedge clk);
                    rtr_i = !(mon_cyc >= 5 && mon_cyc < 9);
                    if (held) begin
                        check("stall valid", rts_o, 1);
                        check("stall hold", {sow_o, eow_o, posit_o}, prev_out);
                    end
                    if (rts_o && rtr_i) begin
                        check($sformatf("stream word %0d", mon_j), {sow_o, eow_o, posit_o},
                              {mon_j == 0, mon_j == 7, bp_posit[mon_j]});
                        mon_j++;
                    end
                    held     = rts_o && !rtr_i;
                    prev_out = {sow_o, eow_o, posit_o};
                    mon_cyc++;
                end
            end
        join
        rtr_i = 1'b1;
        check("stream count", mon_j, 8);
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (rts_o) spurious++;
        end
        check("stream no duplicates", spurious, 0);

        // Reset with words in flight
        @(negedge clk);
        check("pre-reset rtr", rtr_o, 1);
        for (int w = 0; w < 3; w++) begin
            drive(40'h00_0000_1000, 1'b0, w == 0, w == 2);
            @(negedge clk);
        end
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
        @(negedge clk);
        check("pre-reset output", {rts_o, sow_o, posit_o}, {1'b1, 1'b1, 8'h40});
        rst_n = 1'b0;
        #1;
        check("reset flush", {rtr_o, rts_o, sow_o, eow_o, posit_o}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (5) begin
            @(negedge clk);
            if (rts_o) spurious++;
        end
        check("no output after reset", spurious, 0);
        convert("after reset", 40'h00_0000_1000, 1'b0, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
